sync_event_arbiter: RTL
=======================

// Module: sync_event_arbiter
// PURPOSE
//  Qualifies N asynchronous level inputs and queues one pending change event per channel.
//  Each input passes through a synchronizer chain and a stability filter before its change is queued.
//  A round-robin arbiter presents the queued events, one at a time, on a single valid/ready event stream.
//  Sits between board-level GPIO/trigger pins and the AXI-facing event FIFO/interrupt logic.
// PARAMETERS
//  N_CH          4   number of async input channels (1..16)
//  SYNC_DEPTH    2   flops per synchronizer chain; values <2 forced to 2
//  STABLE_COUNT  4   consecutive equal synchronized samples required to qualify a change; <1 forced to 1
// PORTS
//  clk           in   1          single clock; all logic on posedge
//  rst           in   1          synchronous reset, active-high
//  async_in      in   N_CH       raw asynchronous levels
//  ch_enable     in   N_CH       per-channel event enable
//  ovf_clr       in   1          one-cycle pulse; clears all overflow bits
//  evt_valid     out  1          event presented
//  evt_ready     in   1          consumer accepts event
//  evt_ch        out  CH_W       channel index, CH_W = max(1, clog2(N_CH))
//  evt_level     out  1          new qualified level of evt_ch
//  pending       out  N_CH       per-channel queued-event flags
//  overflow      out  N_CH       sticky: change qualified while the previous event was still pending
// BEHAVIOUR
//  Reset:
//   - Outputs: evt_valid=0, evt_ch=0, evt_level=0, pending=0, overflow=0.
//   - Internal state: sync chains=0, qualified levels=0, stability counters=0, RR pointer=0, FSM=IDLE.
//   - rst mid-presentation drops evt_valid the next cycle; no handshake is implied.
//  Qualification, per channel:
//   - sync = last sync flop. The counter increments while sync equals the previous-cycle sync, saturating at STABLE_COUNT.
//   - The counter resets to 0 whenever sync changes.
//   - When counter==STABLE_COUNT-1, sync==previous sync, and sync!=qualified level: qualified level<=sync (qualify pulse).
//   - Latency, with async_in held stable: pin edge to qualify pulse = SYNC_DEPTH+STABLE_COUNT cycles (+/-1 metastability).
//  Pending:
//   - A qualify pulse on an enabled channel sets pending and stores pend_level=new level.
//   - A qualify pulse while pending is already set: overflow set, pend_level overwritten with the latest level.
//   - Qualify pulse in the same cycle as acceptance of that channel: pending stays 1, new level stored, no overflow.
//   - ch_enable=0: pending cleared and qualify pulses ignored; qualified level still tracks the pin (no event on re-enable).
//   - Overflow set and ovf_clr in the same cycle: set wins.
//  Arbiter FSM (IDLE, PRESENT):
//   - IDLE: if any pending&ch_enable, grant the first set channel at or after rr_ptr (wrapping N_CH-1 -> 0).
//     Register evt_ch/evt_level, evt_valid<=1, go to PRESENT.
//   - PRESENT: evt_ch/evt_level/evt_valid are held stable until evt_valid&&evt_ready.
//     On acceptance: clear that channel's pending (subject to the same-cycle rule), rr_ptr<=evt_ch+1 mod N_CH, evt_valid<=0, go to IDLE.
//   - Disabling a presented channel does not retract evt_valid. Its event completes normally and its pending bit stays 0.
//   - Throughput: at most 1 event per 2 cycles; evt_valid is low for at least 1 cycle between events.
// CONFIGURATION
//  SYNC_EVT_TIMESTAMP_EN defined:
//   - Adds a free-running 32-bit cycle counter (reset 0, wraps 2^32-1 -> 0).
//   - Counter value is captured into a per-channel register on each accepted qualify pulse (overwritten on overflow).
//   - Captured value is output as evt_ts[31:0], held with evt_ch; reset value 0.
//  Undefined: no evt_ts port, no counter, no capture registers.
// STRUCTURE
//  Package sync_evt_pkg:
//   - arb_state_t enum {IDLE, PRESENT}
//   - clog2 function and CH_W derivation
//   - TS_W=32 localparam
//  Sub-module sync_evt_channel, instantiated N_CH times:
//   - Contains the synchronizer chain, stability counter, qualified level, pend_level, pending/overflow flags and optional timestamp capture.
//   - Top level holds the round-robin pointer, the FSM and the output registers.
// TESTING
//  - async_in[1] 0->1, held; ready=1, defaults -> evt_valid rises ~7 cycles later with ch=1, level=1; pending[1] cleared after accept.
//  - async_in[2] glitch high for 2 cycles, STABLE_COUNT=4 -> no event, pending stays 0.
//  - ch0 and ch3 qualify together, rr_ptr=0, ready=1 -> events ch0 then ch3, 2 cycles apart.
//    Repeat with rr_ptr=1 -> ch3 first.
//  - ready=0 while ch1 presented; ch2 toggles 1->0->1 qualified -> overflow[2]=1, pend_level=1.
//    ovf_clr -> overflow=0; ovf_clr same cycle as a new overflow -> overflow stays 1.
//  - rst asserted while evt_valid=1 -> next cycle all outputs 0, FSM IDLE; a pin held high re-qualifies and produces exactly one event.
//  - SYNC_EVT_TIMESTAMP_EN defined: two events qualified 100 cycles apart -> evt_ts values differ by 100.

Source files
------------

// File: rtl/sync_evt_pkg.sv
// Shared state type, width helpers and timestamp width for the async event arbiter.
// Optional feature macro: SYNC_EVT_TIMESTAMP_EN (timestamp capture).
package sync_evt_pkg;

  localparam int TS_W = 32;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } arb_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Channel index width; never narrower than one bit.
  function automatic int ch_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/sync_event_arbiter_if.sv
// Event stream bundle: one valid/ready handshake carrying channel, level and optional timestamp.
// Extra evt_ts field present only with SYNC_EVT_TIMESTAMP_EN.
interface sync_event_arbiter_if #(
  parameter int CH_W = 2
);
  import sync_evt_pkg::*;

  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_ch;
  logic            evt_level;
`ifdef SYNC_EVT_TIMESTAMP_EN
  logic [TS_W-1:0] evt_ts;
`endif

  modport master (
    input  evt_ready,
    output evt_valid,
    output evt_ch,
`ifdef SYNC_EVT_TIMESTAMP_EN
    output evt_ts,
`endif
    output evt_level
  );

  modport slave (
    output evt_ready,
    input  evt_valid,
    input  evt_ch,
`ifdef SYNC_EVT_TIMESTAMP_EN
    input  evt_ts,
`endif
    input  evt_level
  );

endinterface

// File: rtl/sync_evt_channel.sv
// One input channel: synchronizer, stability filter, qualified level and single-entry event slot.
// Qualify pulse SYNC_DEPTH+STABLE_COUNT cycles after a stable pin edge; slot overwrites (and flags overflow) when full.
module sync_evt_channel
  import sync_evt_pkg::*;
#(
  parameter int SYNC_DEPTH   = 2,
  parameter int STABLE_COUNT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            async_in,
  input  logic            enable,
  input  logic            accept,
  input  logic            ovf_clr,
`ifdef SYNC_EVT_TIMESTAMP_EN
  input  logic [TS_W-1:0] ts_now,
  output logic [TS_W-1:0] ts_q,
`endif
  output logic            pending,
  output logic            pend_level,
  output logic            overflow
);

  localparam int SD = (SYNC_DEPTH < 2) ? 2 : SYNC_DEPTH;
  localparam int SC = (STABLE_COUNT < 1) ? 1 : STABLE_COUNT;
  localparam int CW = ch_w(SC + 1);

  logic [SD-1:0] sync_chain;
  logic [CW-1:0] stable_cnt;
  logic          sync;
  logic          sync_prev;
  logic          qual_level;
  logic          qualify;
  logic          take;

  assign sync    = sync_chain[SD-1];
  assign qualify = (stable_cnt == CW'(SC - 1)) && (sync == sync_prev) && (sync != qual_level);
  assign take    = qualify && enable;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_chain <= '0;
      sync_prev  <= 1'b0;
      stable_cnt <= '0;
      qual_level <= 1'b0;
      pending    <= 1'b0;
      pend_level <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[SD-2:0], async_in};
      sync_prev  <= sync;

      if (sync != sync_prev)
        stable_cnt <= '0;
      else if (stable_cnt != CW'(SC))
        stable_cnt <= stable_cnt + 1'b1;

      // Level tracks the pin even while disabled, so re-enable raises no stale event.
      if (qualify)
        qual_level <= sync;

      if (!enable) begin
        pending <= 1'b0;
      end else if (qualify) begin
        pending    <= 1'b1;
        pend_level <= sync;
      end else if (accept) begin
        pending <= 1'b0;
      end

      if (take && pending && !accept)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

`ifdef SYNC_EVT_TIMESTAMP_EN
  always_ff @(posedge clk) begin
    if (rst)
      ts_q <= '0;
    else if (take)
      ts_q <= ts_now;
  end
`endif

endmodule

// File: rtl/sync_event_arbiter.sv
// Qualifies N_CH async levels and presents one queued change at a time, round-robin, on a valid/ready stream.
// Event 2 cycles after a qualify pulse; output held under backpressure, >=1 idle cycle between events. Macro: SYNC_EVT_TIMESTAMP_EN.
module sync_event_arbiter
  import sync_evt_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int SYNC_DEPTH   = 2,
  parameter int STABLE_COUNT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH-1:0]     async_in,
  input  logic [N_CH-1:0]     ch_enable,
  input  logic                ovf_clr,
  sync_event_arbiter_if.master evt,
  output logic [N_CH-1:0]     pending,
  output logic [N_CH-1:0]     overflow
);

  localparam int CH_W = ch_w(N_CH);

  arb_state_t      state;
  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] grant_ch;
  logic            grant_vld;
  logic [N_CH-1:0] pend_level;
  logic [N_CH-1:0] pend_en;
  logic [N_CH-1:0] accept_vec;
  logic            accept;
  logic            vld_q;
  logic [CH_W-1:0] ch_q;
  logic            lvl_q;
  int              idx;

`ifdef SYNC_EVT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ch_ts [N_CH];
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk) begin
    if (rst)
      ts_cnt <= '0;
    else
      ts_cnt <= ts_cnt + 1'b1;
  end

  assign evt.evt_ts = ts_q;
`endif

  assign pend_en       = pending & ch_enable;
  assign accept        = vld_q && evt.evt_ready;
  assign evt.evt_valid = vld_q;
  assign evt.evt_ch    = ch_q;
  assign evt.evt_level = lvl_q;

  always_comb begin
    accept_vec = '0;
    for (int i = 0; i < N_CH; i++) begin
      accept_vec[i] = accept && (ch_q == CH_W'(i));
    end
  end

  // First pending+enabled channel at or after rr_ptr, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    idx       = 0;
    for (int i = 0; i < N_CH; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!grant_vld && pend_en[CH_W'(idx)]) begin
        grant_vld = 1'b1;
        grant_ch  = CH_W'(idx);
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    sync_evt_channel #(
      .SYNC_DEPTH  (SYNC_DEPTH),
      .STABLE_COUNT(STABLE_COUNT)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .async_in  (async_in[g]),
      .enable    (ch_enable[g]),
      .accept    (accept_vec[g]),
      .ovf_clr   (ovf_clr),
`ifdef SYNC_EVT_TIMESTAMP_EN
      .ts_now    (ts_cnt),
      .ts_q      (ch_ts[g]),
`endif
      .pending   (pending[g]),
      .pend_level(pend_level[g]),
      .overflow  (overflow[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      vld_q  <= 1'b0;
      ch_q   <= '0;
      lvl_q  <= 1'b0;
`ifdef SYNC_EVT_TIMESTAMP_EN
      ts_q   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            ch_q  <= grant_ch;
            lvl_q <= pend_level[grant_ch];
`ifdef SYNC_EVT_TIMESTAMP_EN
            ts_q  <= ch_ts[grant_ch];
`endif
            vld_q <= 1'b1;
            state <= PRESENT;
          end
        end
        PRESENT: begin
          if (accept) begin
            vld_q  <= 1'b0;
            rr_ptr <= (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
